// File: rtl/mon_pkg.sv
// Shared types for the toggle period monitor.
// State encoding plus lock-counter width helper.
package mon_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } mon_state_e;

    function automatic int lock_cnt_w(input int lock_count);
        return (lock_count < 1) ? 1 : $clog2(lock_count + 1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by a previous-value register.
// edge_o is high for one cycle after each settled level change.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic edge_o
);

    logic s1_q, s2_q, prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign edge_o = s2_q ^ prev_q;

endmodule

// File: rtl/toggle_period_monitor.sv
// Measures half-periods of a slow toggle, tracks lock, flags errors.
// Optional min/max statistics are built when MON_STATS_EN is defined.
module toggle_period_monitor
    import mon_pkg::*;
#(
    parameter int CNT_W         = 17,
    parameter int EXPECTED_HALF = 50001,
    parameter int TOLERANCE     = 2,
    parameter int LOCK_COUNT    = 4,
    parameter int TIMEOUT       = 131000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_clk_in,
    input  logic             err_clr_i,
    output logic [CNT_W-1:0] half_period_o,
    output logic             meas_valid_o,
    output logic             in_tol_o,
    output logic             locked_o,
    output logic             timeout_o,
    output logic             err_o,
    output logic [CNT_W-1:0] min_o,
    output logic [CNT_W-1:0] max_o
);

    localparam int LCW = lock_cnt_w(LOCK_COUNT);
    localparam logic [31:0] LO_B =
        (EXPECTED_HALF > TOLERANCE) ?
        32'(EXPECTED_HALF - TOLERANCE) : 32'd0;
    localparam logic [31:0] HI_B =
        32'(EXPECTED_HALF + TOLERANCE);
    localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_COUNT - 1);

    logic             edge_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      cnt_ext;
    logic             tol_s;
    logic             to_hit;

    mon_state_e       state_q, state_d;
    logic [LCW-1:0]   good_q, good_d;

    logic             meas_s, err_set, to_set;
    logic [CNT_W-1:0] half_q;
    logic             mv_q, tol_q, to_q, err_q;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst   (rst),
        .d_i   (div_clk_in),
        .edge_o(edge_s)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (edge_s)
            cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
    end

    assign cnt_ext = 32'(cnt_q);
    assign tol_s   = (cnt_ext >= LO_B) && (cnt_ext <= HI_B);
    // An edge coinciding with the timeout count wins over the timeout.
    assign to_hit  = (cnt_q == TO_V) && !edge_s;

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        meas_s  = 1'b0;
        err_set = 1'b0;
        to_set  = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (edge_s) begin
                    state_d = TRACK;
                    good_d  = '0;
                end
            end
            TRACK: begin
                if (edge_s) begin
                    meas_s = 1'b1;
                    if (!tol_s) begin
                        good_d = '0;
                    end else if (good_q == LOCK_LAST) begin
                        good_d  = '0;
                        state_d = LOCKED;
                    end else begin
                        good_d = good_q + LCW'(1);
                    end
                end else if (to_hit) begin
                    state_d = SEARCH;
                    good_d  = '0;
                    to_set  = 1'b1;
                    err_set = 1'b1;
                end
            end
            LOCKED: begin
                if (edge_s) begin
                    meas_s = 1'b1;
                    if (!tol_s) begin
                        state_d = TRACK;
                        good_d  = '0;
                        err_set = 1'b1;
                    end
                end else if (to_hit) begin
                    state_d = SEARCH;
                    good_d  = '0;
                    to_set  = 1'b1;
                    err_set = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
                good_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= SEARCH;
            good_q  <= '0;
            half_q  <= '0;
            mv_q    <= 1'b0;
            tol_q   <= 1'b0;
            to_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            good_q  <= good_d;
            mv_q    <= meas_s;
            to_q    <= to_set;
            // A set in the same cycle as a clear keeps the flag.
            err_q   <= err_set | (err_q & ~err_clr_i);
            if (meas_s) begin
                half_q <= cnt_q;
                tol_q  <= tol_s;
            end
        end
    end

    assign half_period_o = half_q;
    assign meas_valid_o  = mv_q;
    assign in_tol_o      = tol_q;
    assign locked_o      = (state_q == LOCKED);
    assign timeout_o     = to_q;
    assign err_o         = err_q;

`ifdef MON_STATS_EN
    logic [CNT_W-1:0] min_q, max_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            min_q <= '1;
            max_q <= '0;
        end else if (meas_s) begin
            if (err_clr_i || (cnt_q < min_q))
                min_q <= cnt_q;
            if (err_clr_i || (cnt_q > max_q))
                max_q <= cnt_q;
        end else if (err_clr_i) begin
            min_q <= '1;
            max_q <= '0;
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;
`else
    assign min_o = '0;
    assign max_o = '0;
`endif

endmodule

// File: tb/tb_toggle_period_monitor.sv
// Directed bench for toggle_period_monitor with small parameters.
// Each vector toggles the input and waits n cycles, then checks.
module tb_toggle_period_monitor;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             div_clk_in;
    logic             err_clr_i;
    logic [CNT_W-1:0] half_period_o;
    logic             meas_valid_o;
    logic             in_tol_o;
    logic             locked_o;
    logic             timeout_o;
    logic             err_o;
    logic [CNT_W-1:0] min_o;
    logic [CNT_W-1:0] max_o;

    int total;
    int passed;

    typedef struct {
        int n;
        int clr_at;
        int mv;
        int half;
        int tol;
        int to_at;
        int lock;
        int err;
        int mn;
        int mx;
    } vec_t;

    vec_t tbl [28];

    toggle_period_monitor #(
        .CNT_W        (CNT_W),
        .EXPECTED_HALF(10),
        .TOLERANCE    (1),
        .LOCK_COUNT   (4),
        .TIMEOUT      (40)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .div_clk_in   (div_clk_in),
        .err_clr_i    (err_clr_i),
        .half_period_o(half_period_o),
        .meas_valid_o (meas_valid_o),
        .in_tol_o     (in_tol_o),
        .locked_o     (locked_o),
        .timeout_o    (timeout_o),
        .err_o        (err_o),
        .min_o        (min_o),
        .max_o        (max_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(int n, int clr_at, int mv, int half,
                                int tol, int to_at, int lock, int err,
                                int mn, int mx);
        vec_t v;
        v.n = n; v.clr_at = clr_at; v.mv = mv; v.half = half;
        v.tol = tol; v.to_at = to_at; v.lock = lock; v.err = err;
        v.mn = mn; v.mx = mx;
        return v;
    endfunction

    function automatic int st_min(int v);
`ifdef MON_STATS_EN
        return v;
`else
        return (v == 12345) ? 1 : 0;
`endif
    endfunction

    function automatic int st_max(int v);
`ifdef MON_STATS_EN
        return v;
`else
        return (v == 12345) ? 1 : 0;
`endif
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int mv_cnt, mv_at, hv, tv, to_cnt, to_at;
        mv_cnt = 0; mv_at = 0; hv = 0; tv = 0;
        to_cnt = 0; to_at = 0;
        div_clk_in = ~div_clk_in;
        err_clr_i  = (v.clr_at == 1);
        for (int i = 1; i <= v.n; i++) begin
            @(posedge clk);
            #1;
            if (meas_valid_o) begin
                mv_cnt++;
                mv_at = i;
                hv = int'(half_period_o);
                tv = int'(in_tol_o);
            end
            if (timeout_o) begin
                to_cnt++;
                to_at = i;
            end
            err_clr_i = (i + 1 == v.clr_at);
        end
        chk({tag, " meas_count"}, mv_cnt, v.mv);
        if (v.mv != 0) begin
            chk({tag, " meas_pos"}, mv_at, 3);
            chk({tag, " half_period"}, hv, v.half);
            chk({tag, " in_tol"}, tv, v.tol);
        end
        chk({tag, " timeout_count"}, to_cnt, (v.to_at != 0) ? 1 : 0);
        if (v.to_at != 0)
            chk({tag, " timeout_pos"}, to_at, v.to_at);
        chk({tag, " locked"}, int'(locked_o), v.lock);
        chk({tag, " err"}, int'(err_o), v.err);
        chk({tag, " min"}, int'(min_o), st_min(v.mn));
        chk({tag, " max"}, int'(max_o), st_max(v.mx));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " half_period"}, int'(half_period_o), 0);
        chk({tag, " meas_valid"}, int'(meas_valid_o), 0);
        chk({tag, " in_tol"}, int'(in_tol_o), 0);
        chk({tag, " locked"}, int'(locked_o), 0);
        chk({tag, " timeout"}, int'(timeout_o), 0);
        chk({tag, " err"}, int'(err_o), 0);
        chk({tag, " min"}, int'(min_o), st_min(255));
        chk({tag, " max"}, int'(max_o), st_max(0));
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst = 1'b1;
        div_clk_in = 1'b0;
        err_clr_i = 1'b0;

        tbl[0]  = mk(10, 0, 0,  0, 0,  0, 0, 0, 255,  0);
        tbl[1]  = mk(10, 0, 1, 10, 1,  0, 0, 0,  10, 10);
        tbl[2]  = mk(10, 0, 1, 10, 1,  0, 0, 0,  10, 10);
        tbl[3]  = mk(10, 0, 1, 10, 1,  0, 0, 0,  10, 10);
        tbl[4]  = mk(13, 0, 1, 10, 1,  0, 1, 0,  10, 10);
        tbl[5]  = mk(10, 0, 1, 13, 0,  0, 0, 1,  10, 13);
        tbl[6]  = mk(10, 0, 1, 10, 1,  0, 0, 1,  10, 13);
        tbl[7]  = mk(10, 0, 1, 10, 1,  0, 0, 1,  10, 13);
        tbl[8]  = mk(10, 0, 1, 10, 1,  0, 0, 1,  10, 13);
        tbl[9]  = mk(10, 0, 1, 10, 1,  0, 1, 1,  10, 13);
        tbl[10] = mk(11, 0, 1, 10, 1,  0, 1, 1,  10, 13);
        tbl[11] = mk( 9, 0, 1, 11, 1,  0, 1, 1,  10, 13);
        tbl[12] = mk(10, 0, 1,  9, 1,  0, 1, 1,   9, 13);
        tbl[13] = mk(10, 6, 1, 10, 1,  0, 1, 0, 255,  0);
        tbl[14] = mk(13, 0, 1, 10, 1,  0, 1, 0,  10, 10);
        tbl[15] = mk(10, 3, 1, 13, 0,  0, 0, 1,  13, 13);
        tbl[16] = mk( 9, 8, 1, 10, 1,  0, 0, 0, 255,  0);
        tbl[17] = mk(11, 0, 1,  9, 1,  0, 0, 0,   9,  9);
        tbl[18] = mk(10, 0, 1, 11, 1,  0, 0, 0,   9, 11);
        tbl[19] = mk(10, 0, 1, 10, 1,  0, 1, 0,   9, 11);
        tbl[20] = mk(45, 0, 1, 10, 1, 43, 0, 1,   9, 11);
        tbl[21] = mk(40, 5, 0,  0, 0,  0, 0, 0, 255,  0);
        tbl[22] = mk(10, 0, 1, 40, 0,  0, 0, 0,  40, 40);
        tbl[23] = mk(10, 0, 1, 10, 1,  0, 0, 0,  10, 40);
        tbl[24] = mk(10, 0, 1, 10, 1,  0, 0, 0,  10, 40);
        tbl[25] = mk(10, 0, 1, 10, 1,  0, 0, 0,  10, 40);
        tbl[26] = mk(10, 0, 1, 10, 1,  0, 1, 0,  10, 40);
        tbl[27] = mk(10, 0, 1, 10, 1,  0, 1, 0,  10, 40);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outs("reset");

        for (int i = 0; i < 28; i++)
            run_vec(tbl[i], $sformatf("v%0d", i));

        chk("prereset locked", int'(locked_o), 1);
        chk("prereset in_tol", int'(in_tol_o), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outs("midlock_reset");

        run_vec(mk(10, 0, 0,  0, 0, 0, 0, 0, 255,  0), "post_rst0");
        run_vec(mk(10, 0, 1, 10, 1, 0, 0, 0,  10, 10), "post_rst1");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/toggle_period_monitor.md
Name: toggle_period_monitor

Overview:
- Receiving end of the divided-clock toggle output: samples a slow toggling signal, measures each half-period in `clk` cycles and checks it against an expected value.
- Reports lock, tolerance violations and loss of toggling (timeout).
- Sits beside the divider in the timing testbed as a self-checking observer, so divider behaviour is visible on-chip.

Parameters:
- CNT_W, 17, width of the half-period counter and measurement output.
- EXPECTED_HALF, 50001, nominal half-period in `clk` cycles.
- TOLERANCE, 2, allowed absolute deviation from EXPECTED_HALF.
- LOCK_COUNT, 4, consecutive in-tolerance measurements needed to lock.
- TIMEOUT, 131000, cycles without an edge before toggling is declared lost; must be < 2^CNT_W-1.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- div_clk_in  in  1  toggling signal under test; treated as asynchronous.
- err_clr_i  in  1  clears err_o (and stats when enabled).
- half_period_o  out  CNT_W  last measured half-period.
- meas_valid_o  out  1  one-cycle pulse when half_period_o updates.
- in_tol_o  out  1  last measurement within tolerance; valid with meas_valid_o, held after.
- locked_o  out  1  high in LOCKED state.
- timeout_o  out  1  one-cycle pulse on timeout.
- err_o  out  1  sticky error flag.
- min_o  out  CNT_W  minimum measurement (MON_STATS_EN); 0 otherwise.
- max_o  out  CNT_W  maximum measurement (MON_STATS_EN); 0 otherwise.

Behaviour:
- Reset
  - While rst=1 at a clk edge, all registers clear.
  - All outputs read 0 the next cycle, except min_o, which reads all-ones when stats are enabled.
  - State returns to SEARCH.
- Input path
  - 2-flop synchroniser, then a previous-value register.
  - edge = sync_q2 ^ prev_q, combinational.
  - Edge is detected 2 clk after the first sampling of the new level.
- Counter cnt_r
  - Increments every cycle and saturates at 2^CNT_W-1.
  - On an edge cycle it loads 1.
  - Input toggling every N cycles therefore measures N.
- Measurement
  - On an edge in TRACK or LOCKED, these register on the same clk (outputs change 1 cycle after the edge cycle):
    - half_period_o <= cnt_r;
    - meas_valid_o <= 1;
    - in_tol_o <= (EXPECTED_HALF-TOLERANCE <= cnt_r <= EXPECTED_HALF+TOLERANCE), with the lower bound clamped at 0.
  - An edge in SEARCH produces no measurement; the partial count is discarded.
- FSM states: SEARCH, TRACK, LOCKED.
  - SEARCH: first edge -> TRACK, good_cnt=0.
  - TRACK: good measurement -> good_cnt+1; when it reaches LOCK_COUNT -> LOCKED. Bad measurement -> good_cnt=0, stay in TRACK (no error).
  - LOCKED: bad measurement -> TRACK, good_cnt=0, err set.
  - TRACK/LOCKED timeout: cnt_r==TIMEOUT with no edge in the same cycle -> SEARCH, timeout_o pulse, err set.
  - An edge in the same cycle as cnt_r==TIMEOUT counts as an edge, not a timeout.
- locked_o = (state==LOCKED), registered.
- err_o: set in the same cycle as the event; err_clr_i clears it. Simultaneous set and clear -> stays 1.
- Reset mid-lock: everything restarts from SEARCH; the first post-reset edge gives no meas_valid_o.

Optional Feature:
- Macro: MON_STATS_EN.
- Defined:
  - min_o/max_o track the min and max of all half_period_o values since reset or err_clr_i.
  - Reset values: min all-ones, max 0.
  - Updated on each meas_valid_o.
  - Clear and measurement in the same cycle -> the measurement becomes both min and max.
- Undefined: no stats registers; min_o and max_o tied to 0. Port list unchanged.

Decomposition:
- Package mon_pkg: state enum (SEARCH/TRACK/LOCKED) and a lock-counter width function ($clog2(LOCK_COUNT+1)).
- Sub-module sync_edge_det: 2-flop synchroniser plus previous register, output edge; reused elsewhere.

Test Plan:
- Bench parameters: CNT_W=8, EXPECTED_HALF=10, TOLERANCE=1, LOCK_COUNT=4, TIMEOUT=40.
- Toggle every 10 clk -> no meas on 1st edge; meas_valid_o per later edge with half_period_o=10, in_tol_o=1; locked_o rises with the 4th meas (5th edge).
- Locked, one half-period of 13 -> half_period_o=13, in_tol_o=0, locked_o=0, err_o=1; then 4 good periods relock.
- Locked, input held -> timeout_o pulse when cnt_r hits 40 (40 cycles after the last edge cycle); state SEARCH, locked_o=0, err_o=1.
- err_clr_i in the same cycle as a locked out-of-tolerance meas -> err_o stays 1; a lone err_clr_i later -> 0.
- rst pulsed 1 cycle while locked -> next cycle all outputs 0; first following edge gives no meas_valid_o.
- MON_STATS_EN: half-periods 9, 11, 10 -> min_o=9, max_o=11; err_clr_i -> min_o=255, max_o=0.
